// File: rtl/rom_fetch_pkg.sv
// Shared types, default widths and ROM contents for the ROM fetch responder.
package rom_fetch_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 16;
  localparam int unsigned ROM_WORDS  = 16;
  localparam int unsigned WORD_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Instruction image; words 0 and 1 have even and odd parity respectively.
  localparam logic [WORD_W-1:0] ROM_INIT [ROM_WORDS] = '{
    8'h3C, 8'hB5, 8'h01, 8'h12, 8'h23, 8'h5A, 8'h67, 8'h78,
    8'h89, 8'h9A, 8'hAB, 8'hC4, 8'hD5, 8'hE6, 8'hF7, 8'hFF
  };

  // Word at index idx, zero beyond the populated image.
  function automatic logic [WORD_W-1:0] rom_word(input int unsigned idx);
    logic [WORD_W-1:0] word;
    word = '0;
    if (idx < ROM_WORDS) word = ROM_INIT[idx[3:0]];
    return word;
  endfunction

endpackage

// File: rtl/rom_table.sv
// Combinational ROM lookup: address -> {err, data}; out-of-range reads return zero.
module rom_table
  import rom_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_c,
  output logic              err_c
);

  // Range check, then fetch the word when in range.
  always_comb begin
    err_c  = (32'(addr) >= DEPTH);
    data_c = '0;
    if (!err_c) data_c = DATA_W'(rom_word(32'(addr)));
  end

endmodule

// File: rtl/rom_fetch_responder.sv
// ROM fetch responder: grants one address request at a time, waits WAIT_STATES
// cycles, then holds the looked-up word until the consumer takes it.
// Optional feature macro: ROM_PARITY_EN adds the registered out_parity output.
module rom_fetch_responder
  import rom_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned DEPTH       = DEPTH_DEF,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              CP,
  input  logic              RST_N,
  input  logic              in_req,
  input  logic [ADDR_W-1:0] in_addr_ROM,
  output logic              out_gnt,
  output logic              out_valid,
  input  logic              in_ready,
  output logic [DATA_W-1:0] out_data_ROM,
  output logic              out_err
`ifdef ROM_PARITY_EN
  ,
  output logic              out_parity
`endif
);

  localparam int unsigned      CNT_W        = 4;
  localparam logic [CNT_W-1:0] WAIT_LOAD    = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;
  localparam state_t           ACCEPT_STATE = (WAIT_STATES > 0) ? WAIT : RESP;
  localparam bit               DIRECT_RESP  = (WAIT_STATES == 0);

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              accept;
  logic              load_resp;
  logic [ADDR_W-1:0] lookup_addr;
  logic [DATA_W-1:0] tbl_data;
  logic              tbl_err;

  // Grant whenever idle, or when the held response is being taken this cycle.
  assign out_gnt     = RST_N & ((state == IDLE) | ((state == RESP) & in_ready));
  assign accept      = in_req & out_gnt;
  // Response registers load on the last wait cycle, or directly on accept with no wait states.
  assign load_resp   = ((state == WAIT) & (wait_cnt == '0)) | (accept & DIRECT_RESP);
  // In WAIT the latched address is looked up; otherwise the address being accepted.
  assign lookup_addr = (state == WAIT) ? addr_q : in_addr_ROM;

  rom_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_rom_table (
    .addr   (lookup_addr),
    .data_c (tbl_data),
    .err_c  (tbl_err)
  );

  // FSM, wait counter, address latch and registered response outputs.
  always_ff @(posedge CP or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      addr_q       <= '0;
      out_valid    <= 1'b0;
      out_data_ROM <= '0;
      out_err      <= 1'b0;
`ifdef ROM_PARITY_EN
      out_parity   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE:    if (accept) state <= ACCEPT_STATE;
        WAIT:    if (wait_cnt == '0) state <= RESP;
        RESP:    if (in_ready) state <= accept ? ACCEPT_STATE : IDLE;
        default: state <= IDLE;
      endcase

      if (accept) begin
        addr_q   <= in_addr_ROM;
        wait_cnt <= WAIT_LOAD;
      end else if ((state == WAIT) && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - CNT_W'(1);
      end

      if (load_resp) begin
        out_valid    <= 1'b1;
        out_data_ROM <= tbl_data;
        out_err      <= tbl_err;
`ifdef ROM_PARITY_EN
        out_parity   <= ^tbl_data;
`endif
      end else if (out_valid && in_ready) begin
        out_valid    <= 1'b0;
        out_data_ROM <= '0;
        out_err      <= 1'b0;
`ifdef ROM_PARITY_EN
        out_parity   <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_rom_fetch_responder.sv
// Directed bench for rom_fetch_responder: instance A has no wait states and full
// depth, instance B has three wait states and twelve populated words.
module tb_rom_fetch_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req_a, ready_a, gnt_a, valid_a, err_a;
  logic [3:0] addr_a;
  logic [7:0] data_a;
  logic       req_b, ready_b, gnt_b, valid_b, err_b;
  logic [3:0] addr_b;
  logic [7:0] data_b;
`ifdef ROM_PARITY_EN
  logic       parity_a, parity_b;
`endif

  int errors = 0;
  int checks = 0;

  localparam logic [7:0] EXP_ROM [16] = '{
    8'h3C, 8'hB5, 8'h01, 8'h12, 8'h23, 8'h5A, 8'h67, 8'h78,
    8'h89, 8'h9A, 8'hAB, 8'hC4, 8'hD5, 8'hE6, 8'hF7, 8'hFF
  };

  rom_fetch_responder #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .WAIT_STATES(0)) dut_a (
    .CP           (clk),
    .RST_N        (rst_n),
    .in_req       (req_a),
    .in_addr_ROM  (addr_a),
    .out_gnt      (gnt_a),
    .out_valid    (valid_a),
    .in_ready     (ready_a),
    .out_data_ROM (data_a),
    .out_err      (err_a)
`ifdef ROM_PARITY_EN
    ,
    .out_parity   (parity_a)
`endif
  );

  rom_fetch_responder #(.ADDR_W(4), .DATA_W(8), .DEPTH(12), .WAIT_STATES(3)) dut_b (
    .CP           (clk),
    .RST_N        (rst_n),
    .in_req       (req_b),
    .in_addr_ROM  (addr_b),
    .out_gnt      (gnt_b),
    .out_valid    (valid_b),
    .in_ready     (ready_b),
    .out_data_ROM (data_b),
    .out_err      (err_b)
`ifdef ROM_PARITY_EN
    ,
    .out_parity   (parity_b)
`endif
  );

  task automatic test_reset();
    rst_n = 1'b0;
    req_a = 1'b0; ready_a = 1'b0; addr_a = 4'h0;
    req_b = 1'b0; ready_b = 1'b0; addr_b = 4'h0;
    #12;
    checks++;
    if (valid_a !== 1'b0 || gnt_a !== 1'b0 || data_a !== 8'h00 || err_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: valid=%0b gnt=%0b data=%h err=%0b, expected 0 0 00 0",
               valid_a, gnt_a, data_a, err_a);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_a !== 1'b1 || valid_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: gnt=%0b valid=%0b, expected 1 0", gnt_a, valid_a);
    end
    // Bring A into RESP with the consumer stalled, then reset.
    req_a = 1'b1; addr_a = 4'h3; ready_a = 1'b0;
    @(negedge clk); req_a = 1'b0;
    checks++;
    if (valid_a !== 1'b1 || data_a !== EXP_ROM[3]) begin
      errors++;
      $display("FAIL reset_setup_resp: valid=%0b data=%h, expected 1 %h", valid_a, data_a, EXP_ROM[3]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid_a !== 1'b0 || data_a !== 8'h00 || gnt_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_resp: valid=%0b data=%h gnt=%0b, expected 0 00 0", valid_a, data_a, gnt_a);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_a !== 1'b1 || valid_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_after: gnt=%0b valid=%0b, expected 1 0", gnt_a, valid_a);
    end
  endtask

  task automatic test_stream();
    @(negedge clk);
    req_a = 1'b1; ready_a = 1'b1; addr_a = 4'h0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      checks++;
      if (valid_a !== 1'b1 || data_a !== EXP_ROM[i-1] || err_a !== 1'b0 || gnt_a !== 1'b1) begin
        errors++;
        $display("FAIL stream_word%0d: valid=%0b data=%h err=%0b gnt=%0b, expected 1 %h 0 1",
                 i - 1, valid_a, data_a, err_a, gnt_a, EXP_ROM[i-1]);
      end
      if (i < 16) addr_a = 4'(i);
      else req_a = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (valid_a !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: valid=%0b, expected 0", valid_a);
    end
    ready_a = 1'b0;
  endtask

  task automatic test_wait_states();
    @(negedge clk);
    req_b = 1'b1; addr_b = 4'h5; ready_b = 1'b0;
    #1;
    checks++;
    if (gnt_b !== 1'b1) begin
      errors++;
      $display("FAIL wait_grant: gnt=%0b, expected 1", gnt_b);
    end
    @(negedge clk); req_b = 1'b0;
    #1;
    checks++;
    if (gnt_b !== 1'b0) begin
      errors++;
      $display("FAIL wait_no_grant: gnt=%0b, expected 0", gnt_b);
    end
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) @(negedge clk);
      checks++;
      if (valid_b !== 1'b0) begin
        errors++;
        $display("FAIL wait_cycle%0d: valid=%0b, expected 0", c, valid_b);
      end
    end
    @(negedge clk);
    checks++;
    if (valid_b !== 1'b1 || data_b !== 8'h5A || err_b !== 1'b0) begin
      errors++;
      $display("FAIL wait_resp: valid=%0b data=%h err=%0b, expected 1 5a 0", valid_b, data_b, err_b);
    end
  endtask

  task automatic test_backpressure();
    req_b = 1'b1; addr_b = 4'hC;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (valid_b !== 1'b1 || data_b !== 8'h5A || err_b !== 1'b0 || gnt_b !== 1'b0) begin
        errors++;
        $display("FAIL stall_cycle%0d: valid=%0b data=%h err=%0b gnt=%0b, expected 1 5a 0 0",
                 c, valid_b, data_b, err_b, gnt_b);
      end
    end
    req_b = 1'b0; ready_b = 1'b1;
    #1;
    checks++;
    if (gnt_b !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_gnt: gnt=%0b, expected 1", gnt_b);
    end
    @(negedge clk);
    checks++;
    if (valid_b !== 1'b0 || err_b !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: valid=%0b err=%0b, expected 0 0", valid_b, err_b);
    end
  endtask

  task automatic test_out_of_range();
    logic [3:0] addrs  [3] = '{4'hC, 4'hF, 4'hB};
    logic [7:0] exp_d  [3] = '{8'h00, 8'h00, 8'hC4};
    logic       exp_e  [3] = '{1'b1, 1'b1, 1'b0};
    int         cyc;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_b = 1'b1; addr_b = addrs[k]; ready_b = 1'b1;
      @(negedge clk); req_b = 1'b0;
      cyc = 0;
      while (valid_b !== 1'b1 && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (valid_b !== 1'b1 || data_b !== exp_d[k] || err_b !== exp_e[k]) begin
        errors++;
        $display("FAIL range_addr%h: valid=%0b data=%h err=%0b, expected 1 %h %0b",
                 addrs[k], valid_b, data_b, err_b, exp_d[k], exp_e[k]);
      end
    end
    @(negedge clk);
    ready_b = 1'b0;
  endtask

`ifdef ROM_PARITY_EN
  task automatic test_parity();
    logic [3:0] addrs [2] = '{4'h1, 4'h0};
    logic       exp_p [2] = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      req_a = 1'b1; addr_a = addrs[k]; ready_a = 1'b0;
      @(negedge clk); req_a = 1'b0;
      checks++;
      if (valid_a !== 1'b1 || parity_a !== exp_p[k]) begin
        errors++;
        $display("FAIL parity_addr%h: valid=%0b parity=%0b, expected 1 %0b", addrs[k], valid_a, parity_a, exp_p[k]);
      end
      ready_a = 1'b1;
      @(negedge clk); ready_a = 1'b0;
      checks++;
      if (valid_a !== 1'b0 || parity_a !== 1'b0) begin
        errors++;
        $display("FAIL parity_idle%0d: valid=%0b parity=%0b, expected 0 0", k, valid_a, parity_a);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_wait_states();
    test_backpressure();
    test_out_of_range();
`ifdef ROM_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
